regfile_wb_arb: RTL
===================

# regfile_wb_arb

Writeback arbiter that owns the single write port of the register file. It merges the in-order pipeline writeback stream, including load-data sign/zero extension, with results from the long-latency multiply/divide unit (MDU). MDU results wait in a 2-entry FIFO, and the block raises a stall request when they starve. Outputs are registered and connect directly to the register file `wen`/`waddr`/`wdata` inputs.

## Interface
- `STARVE_LIMIT`, default 8: consecutive cycles the FIFO head may wait before `stall_req` asserts; legal range 1–255.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `pipe_valid` in 1: pipeline writeback valid this cycle; cannot be back-pressured.
- `pipe_rd` in 5: pipeline destination register.
- `pipe_data` in 32: ALU result, or raw aligned 32-bit memory word for loads.
- `pipe_is_load` in 1: apply load extension to `pipe_data`.
- `pipe_funct3` in 3: load type.
- `pipe_addr_lo` in 2: load byte offset.
- `mdu_valid` in 1: MDU result offered.
- `mdu_ready` out 1: FIFO can accept.
- `mdu_rd` in 5: MDU destination register.
- `mdu_data` in 32: MDU result.
- `wen` out 1: register-file write enable, registered.
- `waddr` out 5: register-file write address, registered.
- `wdata` out 32: register-file write data, registered.
- `stall_req` out 1: request upstream to hold `pipe_valid` low, registered.
- `mdu_pending` out 1: FIFO non-empty.

## Operation
- **Port claim.** The pipeline claims the port when `pipe_valid && pipe_rd != 0`. A pipeline claim always wins, unconditionally.
- **MDU handshake.** Transfer occurs when `mdu_valid && mdu_ready`.
  - `mdu_ready = rst_n && (count != 2)`, decided from the current count only. A same-cycle dequeue does not free space for an enqueue while full.
- **rd = 0 results.** Accepted MDU results with `mdu_rd == 0` are dropped and never enqueued. Pipeline results with `pipe_rd == 0` never write and do not claim the port.
- **MDU write selection.** When the port is unclaimed:
  - FIFO non-empty: dequeue the head and write it.
  - FIFO empty with a transfer this cycle: write the incoming result directly (bypass) and do not enqueue it.
- **FIFO ordering.** Strictly in order; write and read pointers are 1 bit each; count is 0..2.
- **Load extension** (`pipe_is_load = 1`), with `b = pipe_data[8*addr_lo +: 8]` and `h = pipe_data[16*addr_lo[1] +: 16]`:
  - 000 (lb): sign-extend `b`.
  - 001 (lh): sign-extend `h`.
  - 100 (lbu): zero-extend `b`.
  - 101 (lhu): zero-extend `h`.
  - 010 and all other codes: full word.
  - `addr_lo[0]` is ignored for halfwords; misalignment is handled upstream.
  - `pipe_is_load = 0`: `pipe_data` passes unchanged.
- **Starvation counter** (8 bits, saturating at `STARVE_LIMIT`):
  - Increments each cycle the FIFO is non-empty and the head is not written.
  - Clears on any head dequeue or when the FIFO is empty.
  - `stall_req` registers `(counter >= STARVE_LIMIT)` and stays high until the head drains.
  - If the pipeline still claims the port while `stall_req` is high, the pipeline wins; there is no error flag.
- **Reset** (`rst_n = 0` at an edge):
  - `wen = 0`, `waddr = 0`, `wdata = 0`, `stall_req = 0`, counter 0, FIFO emptied.
  - `mdu_pending = 0` and `mdu_ready = 0` while `rst_n` is low.
  - In-flight FIFO entries are discarded with no write. Inputs presented in the reset cycle are ignored.

## Timing
- **Write latency.** Input cycle N → `wen`/`waddr`/`wdata` valid in cycle N+1 → register file updated at the end-of-N+1 edge.
  - Register-file reads in cycle N+1 return the old value. Upstream forwarding compares against `waddr`/`wdata` when `wen = 1`.
- **Idle cycle.** When no write is selected, `wen = 0` and `waddr`/`wdata` hold their previous values.
- **Bypass latency.** An MDU result on an idle port in cycle N writes in cycle N+1.
- **Queued latency.** A queued MDU result writes in the cycle after its first free port.
- **Stall request.** `stall_req` rises `STARVE_LIMIT + 1` cycles after the head first waits, then falls the cycle after the head dequeue.
- **Throughput.** Up to one write per cycle. The FIFO absorbs 2 results during continuous pipeline traffic; a third is back-pressured.

## Test plan
- **Pipeline load.** Pipeline load with `pipe_funct3 = 000`, `pipe_addr_lo = 2`, `pipe_data = 0x00800000`, `pipe_rd = 5`, cycle N → cycle N+1 `wen = 1`, `waddr = 5`, `wdata = 0xFFFFFF80`. Repeat with `pipe_funct3 = 101` and `pipe_addr_lo = 2`, `pipe_data = 0x80010000` → `wdata = 0x00008001`.
- **Collision.** Same-cycle pipeline `rd = 3` and MDU `rd = 7`/`0x1234`, then an idle cycle → `x3` written in N+1, `x7 = 0x1234` in N+2, `mdu_pending` high for exactly one cycle.
- **Back-pressure.** Continuous pipeline claims with 3 MDU offers → first 2 accepted, `mdu_ready = 0` on the third. When the pipeline idles, entries write in order, then the third is accepted.
- **Starvation** (`STARVE_LIMIT = 4`). One queued entry with pipeline claims every cycle → `stall_req` high on the 5th wait cycle. With `pipe_valid` then low, the head writes and `stall_req` drops the next cycle.
- **rd = 0 drops.** Writes with `rd = 0` from either source → `wen` never asserts, and the FIFO count is unchanged.
- **Reset mid-operation.** `rst_n` low for 1 cycle with 2 entries queued → all outputs 0 next cycle, no later writes of those entries, `mdu_ready = 1` after release.

Source files
------------

// File: rtl/regfile_wb_arb.sv
// Register-file writeback arbiter: merges the pipeline writeback, including load
// extension, with MDU results buffered in a 2-entry FIFO. Raises stall_req when the FIFO head starves.
module regfile_wb_arb #(
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pipe_valid,
    input  logic [4:0]  pipe_rd,
    input  logic [31:0] pipe_data,
    input  logic        pipe_is_load,
    input  logic [2:0]  pipe_funct3,
    input  logic [1:0]  pipe_addr_lo,
    input  logic        mdu_valid,
    output logic        mdu_ready,
    input  logic [4:0]  mdu_rd,
    input  logic [31:0] mdu_data,
    output logic        wen,
    output logic [4:0]  waddr,
    output logic [31:0] wdata,
    output logic        stall_req,
    output logic        mdu_pending
);

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    function automatic logic [31:0] load_ext(
        input logic [31:0] data,
        input logic        is_load,
        input logic [2:0]  funct3,
        input logic [1:0]  lo
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lo)
            2'd0:    b = data[7:0];
            2'd1:    b = data[15:8];
            2'd2:    b = data[23:16];
            default: b = data[31:24];
        endcase
        h = lo[1] ? data[31:16] : data[15:0];
        if (!is_load) begin
            r = data;
        end else begin
            case (funct3)
                3'b000:  r = {{24{b[7]}}, b};
                3'b001:  r = {{16{h[15]}}, h};
                3'b100:  r = {24'd0, b};
                3'b101:  r = {16'd0, h};
                default: r = data;
            endcase
        end
        return r;
    endfunction

    logic [31:0] fifo_data_r [2];
    logic [4:0]  fifo_rd_r   [2];
    logic        wptr_r;
    logic        rptr_r;
    logic [1:0]  count_r;
    logic [7:0]  starve_r;
    logic        wen_r;
    logic [4:0]  waddr_r;
    logic [31:0] wdata_r;
    logic        stall_req_r;

    logic        pipe_claim_s;
    logic        xfer_nz_s;
    logic        deq_s;
    logic        enq_s;
    logic        sel_wen_s;
    logic [4:0]  sel_addr_s;
    logic [31:0] sel_data_s;
    logic [1:0]  count_next_s;
    logic [7:0]  starve_next_s;

    // Ready depends only on the current occupancy, never on a same-cycle dequeue.
    assign mdu_ready    = rst_n && (count_r != 2'd2);
    assign mdu_pending  = rst_n && (count_r != 2'd0);
    assign pipe_claim_s = pipe_valid && (pipe_rd != 5'd0);
    assign xfer_nz_s    = mdu_valid && mdu_ready && (mdu_rd != 5'd0);

    assign wen       = wen_r;
    assign waddr     = waddr_r;
    assign wdata     = wdata_r;
    assign stall_req = stall_req_r;

    // Port selection: pipeline first, then FIFO head, then a bypassed MDU result.
    always_comb begin
        deq_s      = 1'b0;
        enq_s      = 1'b0;
        sel_wen_s  = 1'b0;
        sel_addr_s = waddr_r;
        sel_data_s = wdata_r;
        if (pipe_claim_s) begin
            sel_wen_s  = 1'b1;
            sel_addr_s = pipe_rd;
            sel_data_s = load_ext(pipe_data, pipe_is_load, pipe_funct3, pipe_addr_lo);
            enq_s      = xfer_nz_s;
        end else if (count_r != 2'd0) begin
            deq_s      = 1'b1;
            sel_wen_s  = 1'b1;
            sel_addr_s = fifo_rd_r[rptr_r];
            sel_data_s = fifo_data_r[rptr_r];
            enq_s      = xfer_nz_s;
        end else if (xfer_nz_s) begin
            sel_wen_s  = 1'b1;
            sel_addr_s = mdu_rd;
            sel_data_s = mdu_data;
        end else begin
            sel_wen_s  = 1'b0;
        end
    end

    // Next FIFO occupancy and starvation count.
    always_comb begin
        count_next_s  = count_r;
        starve_next_s = starve_r;
        case ({enq_s, deq_s})
            2'b10:   count_next_s = count_r + 2'd1;
            2'b01:   count_next_s = count_r - 2'd1;
            default: count_next_s = count_r;
        endcase
        if ((count_r == 2'd0) || deq_s) begin
            starve_next_s = 8'd0;
        end else if (starve_r >= LIMIT) begin
            starve_next_s = starve_r;
        end else begin
            starve_next_s = starve_r + 8'd1;
        end
    end

    // State and registered write-port outputs; stall_req tracks the updated count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wen_r          <= 1'b0;
            waddr_r        <= 5'd0;
            wdata_r        <= 32'd0;
            stall_req_r    <= 1'b0;
            starve_r       <= 8'd0;
            count_r        <= 2'd0;
            wptr_r         <= 1'b0;
            rptr_r         <= 1'b0;
            fifo_data_r[0] <= 32'd0;
            fifo_data_r[1] <= 32'd0;
            fifo_rd_r[0]   <= 5'd0;
            fifo_rd_r[1]   <= 5'd0;
        end else begin
            wen_r       <= sel_wen_s;
            waddr_r     <= sel_addr_s;
            wdata_r     <= sel_data_s;
            count_r     <= count_next_s;
            starve_r    <= starve_next_s;
            stall_req_r <= (starve_next_s >= LIMIT);
            if (enq_s) begin
                fifo_data_r[wptr_r] <= mdu_data;
                fifo_rd_r[wptr_r]   <= mdu_rd;
                wptr_r              <= ~wptr_r;
            end
            if (deq_s) begin
                rptr_r <= ~rptr_r;
            end
        end
    end

endmodule
